// File: rtl/singing_cmd_pkg.sv
// Shared constants, state encodings and decode helpers for the UART command receiver.
package singing_cmd_pkg;

    localparam logic [7:0]  CMD_ON   = 8'hFF;
    localparam logic [7:0]  CMD_OFF  = 8'h00;
    localparam int unsigned NUM_FREQ = 8;

    // Frequency select codes driven to the RF generation logic.
    localparam logic [2:0] FREQ_12K  = 3'd0;
    localparam logic [2:0] FREQ_48K  = 3'd1;
    localparam logic [2:0] FREQ_1M   = 3'd2;
    localparam logic [2:0] FREQ_10M  = 3'd3;
    localparam logic [2:0] FREQ_40M  = 3'd4;
    localparam logic [2:0] FREQ_100M = 3'd5;
    localparam logic [2:0] FREQ_200M = 3'd6;
    localparam logic [2:0] FREQ_360M = 3'd7;

    typedef enum logic [1:0] {
        BitIdle,
        BitStart,
        BitData,
        BitStop
    } bit_state_e;

    typedef enum logic {
        CmdWaitB1,
        CmdWaitB2
    } cmd_state_e;

    // Only ON and OFF may open a command pair.
    function automatic logic is_lead_byte(logic [7:0] b);
        return (b == CMD_ON) || (b == CMD_OFF);
    endfunction

    function automatic logic is_freq_code(logic [7:0] b);
        return {24'd0, b} < NUM_FREQ;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser plus start/data/stop bit FSM.
module uart_rx_byte
    import singing_cmd_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 833
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_byte_valid_o,
    output logic       frame_err_o
);

    localparam int unsigned     CntW    = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    // Parking value after a low stop bit: waiting for the line to return high.
    localparam logic [CntW-1:0] CntDone = CntW'(CLKS_PER_BIT);

    logic            rx_meta_q;
    logic            rxs_q;
    bit_state_e      state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic [7:0]      rx_byte_q;
    logic            valid_q;
    logic            ferr_q;

    // Synchronise the asynchronous line; idles high so reset to 1.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rxs_q     <= rx_meta_q;
        end
    end

    // Bit FSM: mid-bit sampling, LSB first, registered pulse outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= BitIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            rx_byte_q <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            unique case (state_q)
                BitIdle: begin
                    if (!rxs_q) begin
                        state_q <= BitStart;
                        cnt_q   <= '0;
                    end
                end
                BitStart: begin
                    if (cnt_q == CntHalf) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rxs_q ? BitIdle : BitData;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                BitData: begin
                    if (cnt_q == CntLast) begin
                        cnt_q     <= '0;
                        shift_q   <= {rxs_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= BitStop;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                BitStop: begin
                    if (cnt_q == CntLast) begin
                        if (rxs_q) begin
                            rx_byte_q <= shift_q;
                            valid_q   <= 1'b1;
                            state_q   <= BitIdle;
                            cnt_q     <= '0;
                        end else begin
                            ferr_q <= 1'b1;
                            cnt_q  <= CntDone;
                        end
                    end else if (cnt_q == CntDone) begin
                        // Hold off until the break ends so it cannot look like a start bit.
                        if (rxs_q) begin
                            state_q <= BitIdle;
                            cnt_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= BitIdle;
            endcase
        end
    end

    assign rx_byte_o       = rx_byte_q;
    assign rx_byte_valid_o = valid_q;
    assign frame_err_o     = ferr_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// Two-byte UART command parser driving oscillator enable and frequency select.
module uart_cmd_rx
    import singing_cmd_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 833,
    parameter int unsigned TIMEOUT_CLKS = 48000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic       osc_en_o,
    output logic [2:0] freq_sel_o,
    output logic       cmd_valid_o,
    output logic       cmd_err_o,
    output logic       frame_err_o,
    output logic [7:0] rx_byte_o,
    output logic       rx_byte_valid_o
);

    localparam int unsigned     TmoW   = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CLKS);

    cmd_state_e      state_q;
    logic [7:0]      b1_q;
    logic [TmoW-1:0] tmo_q;
    logic            osc_en_q;
    logic [2:0]      freq_sel_q;
    logic            cmd_valid_q;
    logic            cmd_err_q;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .rx_i           (rx_i),
        .rx_byte_o      (rx_byte_o),
        .rx_byte_valid_o(rx_byte_valid_o),
        .frame_err_o    (frame_err_o)
    );

    // Command FSM: pair up bytes, apply legal pairs, drop everything else.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= CmdWaitB1;
            b1_q        <= '0;
            tmo_q       <= '0;
            osc_en_q    <= 1'b0;
            freq_sel_q  <= '0;
            cmd_valid_q <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            cmd_valid_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            unique case (state_q)
                CmdWaitB1: begin
                    if (rx_byte_valid_o) begin
                        if (is_lead_byte(rx_byte_o)) begin
                            b1_q    <= rx_byte_o;
                            tmo_q   <= '0;
                            state_q <= CmdWaitB2;
                        end else begin
                            cmd_err_q <= 1'b1;
                        end
                    end
                end
                CmdWaitB2: begin
                    // Byte arrival takes priority over timeout.
                    if (rx_byte_valid_o) begin
                        state_q <= CmdWaitB1;
                        tmo_q   <= '0;
                        if (b1_q == CMD_ON && is_freq_code(rx_byte_o)) begin
                            freq_sel_q  <= rx_byte_o[2:0];
                            osc_en_q    <= 1'b1;
                            cmd_valid_q <= 1'b1;
                        end else if (b1_q == CMD_OFF && rx_byte_o == CMD_OFF) begin
                            osc_en_q    <= 1'b0;
                            cmd_valid_q <= 1'b1;
                        end else begin
                            cmd_err_q <= 1'b1;
                        end
                    end else if (frame_err_o || tmo_q == TmoMax) begin
                        state_q <= CmdWaitB1;
                        tmo_q   <= '0;
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
                end
                default: state_q <= CmdWaitB1;
            endcase
        end
    end

    assign osc_en_o    = osc_en_q;
    assign freq_sel_o  = freq_sel_q;
    assign cmd_valid_o = cmd_valid_q;
    assign cmd_err_o   = cmd_err_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Self-checking bench for uart_cmd_rx with a byte-level reference model.
module tb_uart_cmd_rx;

    localparam int unsigned CPB = 16;
    localparam int unsigned TMO = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       osc_en;
    logic [2:0] freq_sel;
    logic       cmd_valid;
    logic       cmd_err;
    logic       frame_err;
    logic [7:0] rx_byte;
    logic       rx_byte_valid;

    always #5 clk = ~clk;

    uart_cmd_rx #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .rx_i           (rx),
        .osc_en_o       (osc_en),
        .freq_sel_o     (freq_sel),
        .cmd_valid_o    (cmd_valid),
        .cmd_err_o      (cmd_err),
        .frame_err_o    (frame_err),
        .rx_byte_o      (rx_byte),
        .rx_byte_valid_o(rx_byte_valid)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Observed pulse counts and pulses not preceded by rx_byte_valid one cycle earlier.
    int   c_valid = 0, c_err = 0, c_ferr = 0, c_rbv = 0, c_lat = 0;
    logic rbv_prev = 1'b0;
    always @(posedge clk) begin
        if (cmd_valid)     c_valid <= c_valid + 1;
        if (cmd_err)       c_err   <= c_err + 1;
        if (frame_err)     c_ferr  <= c_ferr + 1;
        if (rx_byte_valid) c_rbv   <= c_rbv + 1;
        if ((cmd_valid || cmd_err) && !rbv_prev) c_lat <= c_lat + 1;
        rbv_prev <= rx_byte_valid;
    end

    // Reference model: command pairing at byte level.
    logic [7:0] m_pend[$];
    logic       m_osc;
    logic [2:0] m_freq;
    logic [7:0] m_rxb;
    int e_valid, e_err, e_ferr, e_rbv;
    int b_valid, b_err, b_ferr, b_rbv;

    function automatic void model_reset();
        m_pend.delete();
        m_osc  = 1'b0;
        m_freq = 3'd0;
        m_rxb  = 8'h00;
    endfunction

    function automatic void model_byte(logic [7:0] b);
        logic [7:0] b1;
        e_rbv++;
        m_rxb = b;
        if (m_pend.size() == 0) begin
            if (b == 8'hFF || b == 8'h00) m_pend.push_back(b);
            else e_err++;
        end else begin
            b1 = m_pend.pop_front();
            if (b1 == 8'hFF && b < 8) begin
                m_osc  = 1'b1;
                m_freq = b[2:0];
                e_valid++;
            end else if (b1 == 8'h00 && b == 8'h00) begin
                m_osc = 1'b0;
                e_valid++;
            end else begin
                e_err++;
            end
        end
    endfunction

    function automatic void model_frame_err();
        e_ferr++;
        m_pend.delete();
    endfunction

    task automatic snap();
        @(negedge clk);
        b_valid = c_valid; b_err = c_err; b_ferr = c_ferr; b_rbv = c_rbv;
        e_valid = 0; e_err = 0; e_ferr = 0; e_rbv = 0;
    endtask

    // Values captured one cycle after a mid-byte reset.
    logic       r_osc;
    logic [2:0] r_freq;
    logic [7:0] r_rxb;

    // Frame = start, 8 data LSB first, stop, one idle bit. rst_at >= 0 pulses reset there.
    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int rst_at);
        logic [10:0] frame;
        int cyc;
        frame = {1'b1, stop_ok, b, 1'b0};
        cyc = 0;
        for (int i = 0; i < 11; i++) begin
            rx = frame[i];
            for (int k = 0; k < int'(CPB); k++) begin
                @(negedge clk);
                if (rst_at >= 0) begin
                    if (cyc == rst_at + 1) begin
                        r_osc  = osc_en;
                        r_freq = freq_sel;
                        r_rxb  = rx_byte;
                    end
                    rst = (cyc == rst_at);
                end
                cyc++;
            end
        end
    endtask

    task automatic send_good(input logic [7:0] b);
        send_byte(b, 1'b1, -1);
        model_byte(b);
        repeat ($urandom_range(0, 20)) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        n_tests++;
        if (osc_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_osc_en got %b want 0", osc_en);
        end
        n_tests++;
        if (freq_sel !== 3'd0) begin
            n_fail++; $display("FAIL reset_freq_sel got %0d want 0", freq_sel);
        end
        n_tests++;
        if (rx_byte !== 8'h00) begin
            n_fail++; $display("FAIL reset_rx_byte got %h want 00", rx_byte);
        end
        n_tests++;
        if ({cmd_valid, cmd_err, frame_err, rx_byte_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_pulses got %b want 0000",
                     {cmd_valid, cmd_err, frame_err, rx_byte_valid});
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_on_cmd();
        snap();
        send_good(8'hFF);
        send_good(8'h03);
        n_tests++;
        if (c_valid - b_valid !== e_valid || e_valid != 1) begin
            n_fail++; $display("FAIL on_cmd_valid got %0d want %0d", c_valid - b_valid, e_valid);
        end
        n_tests++;
        if (c_err - b_err + c_ferr - b_ferr !== 0) begin
            n_fail++; $display("FAIL on_cmd_errs got %0d want 0", c_err - b_err + c_ferr - b_ferr);
        end
        n_tests++;
        if ({osc_en, freq_sel, rx_byte} !== {m_osc, m_freq, m_rxb}) begin
            n_fail++;
            $display("FAIL on_cmd_outputs got osc=%b freq=%0d byte=%h want osc=%b freq=%0d byte=%h",
                     osc_en, freq_sel, rx_byte, m_osc, m_freq, m_rxb);
        end
    endtask

    task automatic test_off_then_on();
        snap();
        send_good(8'h00);
        send_good(8'h00);
        n_tests++;
        if ({osc_en, freq_sel} !== {m_osc, m_freq}) begin
            n_fail++;
            $display("FAIL off_cmd got osc=%b freq=%0d want osc=%b freq=%0d",
                     osc_en, freq_sel, m_osc, m_freq);
        end
        send_good(8'hFF);
        send_good(8'h07);
        n_tests++;
        if ({osc_en, freq_sel} !== {m_osc, m_freq}) begin
            n_fail++;
            $display("FAIL on7_cmd got osc=%b freq=%0d want osc=%b freq=%0d",
                     osc_en, freq_sel, m_osc, m_freq);
        end
        n_tests++;
        if (c_valid - b_valid !== e_valid) begin
            n_fail++; $display("FAIL off_on_valid got %0d want %0d", c_valid - b_valid, e_valid);
        end
    endtask

    task automatic test_cmd_errors();
        snap();
        send_good(8'hFF);
        send_good(8'h09);
        send_good(8'h5A);
        n_tests++;
        if (c_err - b_err !== e_err || e_err != 2) begin
            n_fail++; $display("FAIL cmd_err_count got %0d want %0d", c_err - b_err, e_err);
        end
        n_tests++;
        if ({osc_en, freq_sel} !== {m_osc, m_freq}) begin
            n_fail++;
            $display("FAIL cmd_err_hold got osc=%b freq=%0d want osc=%b freq=%0d",
                     osc_en, freq_sel, m_osc, m_freq);
        end
        send_good(8'hFF);
        send_good(8'h01);
        n_tests++;
        if ({osc_en, freq_sel, c_valid - b_valid} !== {m_osc, m_freq, e_valid}) begin
            n_fail++;
            $display("FAIL cmd_err_recover got osc=%b freq=%0d want osc=%b freq=%0d",
                     osc_en, freq_sel, m_osc, m_freq);
        end
    endtask

    task automatic test_frame_glitch();
        logic [7:0] b;
        snap();
        b = 8'($urandom_range(0, 255));
        send_byte(b, 1'b0, -1);
        model_frame_err();
        n_tests++;
        if (c_ferr - b_ferr !== e_ferr || c_rbv - b_rbv !== e_rbv) begin
            n_fail++;
            $display("FAIL frame_err got ferr=%0d rbv=%0d want ferr=%0d rbv=%0d",
                     c_ferr - b_ferr, c_rbv - b_rbv, e_ferr, e_rbv);
        end
        n_tests++;
        if (rx_byte !== m_rxb) begin
            n_fail++; $display("FAIL frame_err_rx_byte got %h want %h", rx_byte, m_rxb);
        end
        snap();
        rx = 1'b0;
        repeat ($urandom_range(1, CPB / 2 - 3)) @(negedge clk);
        rx = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        n_tests++;
        if ((c_valid - b_valid) + (c_err - b_err) + (c_ferr - b_ferr) + (c_rbv - b_rbv) !== 0) begin
            n_fail++;
            $display("FAIL glitch_pulses got v=%0d e=%0d f=%0d r=%0d want all 0",
                     c_valid - b_valid, c_err - b_err, c_ferr - b_ferr, c_rbv - b_rbv);
        end
        // Framing error while waiting for byte 2 abandons the pair silently.
        snap();
        send_good(8'hFF);
        send_byte(8'h55, 1'b0, -1);
        model_frame_err();
        send_good(8'h03);
        n_tests++;
        if (c_err - b_err !== e_err || c_valid - b_valid !== e_valid) begin
            n_fail++;
            $display("FAIL ferr_in_b2 got err=%0d valid=%0d want err=%0d valid=%0d",
                     c_err - b_err, c_valid - b_valid, e_err, e_valid);
        end
    endtask

    task automatic test_timeout();
        snap();
        send_good(8'hFF);
        repeat (TMO + 500) @(negedge clk);
        m_pend.delete();
        send_good(8'h02);
        n_tests++;
        if (c_err - b_err !== e_err || e_err != 1) begin
            n_fail++; $display("FAIL timeout_err got %0d want %0d", c_err - b_err, e_err);
        end
        n_tests++;
        if ({osc_en, freq_sel} !== {m_osc, m_freq}) begin
            n_fail++;
            $display("FAIL timeout_hold got osc=%b freq=%0d want osc=%b freq=%0d",
                     osc_en, freq_sel, m_osc, m_freq);
        end
    endtask

    task automatic test_reset_mid();
        snap();
        send_good(8'hFF);
        send_byte(8'h04, 1'b1, 2 * CPB + CPB / 2);
        model_reset();
        n_tests++;
        if ({r_osc, r_freq, r_rxb} !== {1'b0, 3'd0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_mid_outputs got osc=%b freq=%0d byte=%h want 0 0 00",
                     r_osc, r_freq, r_rxb);
        end
        // Remainder of the aborted frame may decode as a stray byte; let it time out.
        repeat (TMO + 300) @(negedge clk);
        n_tests++;
        if (c_valid - b_valid !== 0) begin
            n_fail++; $display("FAIL reset_mid_valid got %0d want 0", c_valid - b_valid);
        end
        snap();
        send_good(8'hFF);
        send_good(8'h04);
        n_tests++;
        if ({osc_en, freq_sel, c_valid - b_valid} !== {m_osc, m_freq, e_valid}) begin
            n_fail++;
            $display("FAIL reset_mid_recover got osc=%b freq=%0d want osc=%b freq=%0d",
                     osc_en, freq_sel, m_osc, m_freq);
        end
    endtask

    task automatic test_random();
        int op;
        int sel;
        logic [7:0] b;
        snap();
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 19);
            if (op == 0) begin
                b = 8'($urandom_range(0, 255));
                send_byte(b, 1'b0, -1);
                model_frame_err();
            end else if (op == 1) begin
                repeat (TMO + 200) @(negedge clk);
                m_pend.delete();
            end else begin
                sel = $urandom_range(0, 3);
                if (sel == 0)      b = 8'hFF;
                else if (sel == 1) b = 8'h00;
                else if (sel == 2) b = 8'($urandom_range(0, 9));
                else               b = 8'($urandom_range(0, 255));
                send_good(b);
            end
            n_tests++;
            if ({osc_en, freq_sel, rx_byte} !== {m_osc, m_freq, m_rxb}) begin
                n_fail++;
                $display("FAIL random_%0d got osc=%b freq=%0d byte=%h want osc=%b freq=%0d byte=%h",
                         i, osc_en, freq_sel, rx_byte, m_osc, m_freq, m_rxb);
            end
        end
        n_tests++;
        if ({c_valid - b_valid, c_err - b_err, c_ferr - b_ferr, c_rbv - b_rbv} !==
            {e_valid, e_err, e_ferr, e_rbv}) begin
            n_fail++;
            $display("FAIL random_counts got v=%0d e=%0d f=%0d r=%0d want v=%0d e=%0d f=%0d r=%0d",
                     c_valid - b_valid, c_err - b_err, c_ferr - b_ferr, c_rbv - b_rbv,
                     e_valid, e_err, e_ferr, e_rbv);
        end
        n_tests++;
        if (c_lat !== 0) begin
            n_fail++; $display("FAIL cmd_latency got %0d misaligned pulses want 0", c_lat);
        end
    endtask

    initial begin
        test_reset();
        test_on_cmd();
        test_off_then_on();
        test_cmd_errors();
        test_frame_glitch();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
- Receiving end of the 2-byte UART command protocol (57600 baud, 8N1, LSB first) on the FTDI RX line.
- Deserialises bytes from the raw serial line and parses command pairs:
  - 0xFF + code selects one of 8 RF frequencies and turns the output on.
  - 0x00 0x00 turns the output off.
- Drives the oscillator enable and frequency-select inputs of the RF generation logic in singing_fpga_top.

Parameters:
- CLKS_PER_BIT, 833, clk cycles per UART bit (48 MHz / 57600).
- TIMEOUT_CLKS, 48000, max clk cycles from byte-1 accept to byte-2 stop-bit sample (1 ms).
- NUM_FREQ, 8, number of valid frequency codes (0..NUM_FREQ-1).

Ports:
- clk  in  1  system clock, 48 MHz.
- rst  in  1  synchronous active-high reset.
- rx  in  1  asynchronous serial input, idle high.
- osc_en  out  1  oscillator output enable (LED_0 source).
- freq_sel  out  3  selected frequency code.
- cmd_valid  out  1  1-cycle pulse: a command was applied.
- cmd_err  out  1  1-cycle pulse: an illegal byte pair or illegal byte 1 was discarded.
- frame_err  out  1  1-cycle pulse: stop bit sampled low.
- rx_byte  out  8  last received byte (debug).
- rx_byte_valid  out  1  1-cycle pulse: rx_byte updated.

Behaviour:
- Reset values (cycle after rst is high at a clk edge):
  - osc_en=0, freq_sel=0, all pulses 0, rx_byte=0x00.
  - Both FSMs go to IDLE. Sync flops are set to 1.
  - Reset mid-byte or mid-command aborts it with no pulses.
- rx passes through a 2-flop synchroniser (reset value 1). All logic uses the synchronised rxs.
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE: rxs=0 -> START, counter cleared.
  - START: at count CLKS_PER_BIT/2 (416), if rxs=1 the start was a glitch -> IDLE with no pulse; otherwise -> DATA, counter cleared.
  - DATA: sample rxs every CLKS_PER_BIT into shift register, LSB first. After 8 samples -> STOP.
  - STOP: sample after CLKS_PER_BIT.
    - rxs=1: rx_byte loaded and rx_byte_valid pulses in the next cycle.
    - rxs=0: frame_err pulses, byte discarded, rx_byte unchanged.
    - Then wait for rxs=1 before IDLE, so a break does not retrigger.
- Command FSM states: WAIT_B1, WAIT_B2.
  - WAIT_B1 on byte:
    - 0xFF or 0x00: latch b1, clear timeout counter, go to WAIT_B2.
    - Anything else: cmd_err pulse, stay in WAIT_B1.
  - WAIT_B2 on byte b2:
    - b1=0xFF and b2<NUM_FREQ: freq_sel<=b2[2:0], osc_en<=1, cmd_valid pulse.
    - b1=0x00 and b2=0x00: osc_en<=0, freq_sel held, cmd_valid pulse.
    - Otherwise: cmd_err pulse, outputs unchanged.
    - All cases return to WAIT_B1.
  - Outputs update and pulses fire in the cycle after rx_byte_valid. Latency from byte-2 stop sample is 2 cycles.
  - WAIT_B2 timeout: counter reaches TIMEOUT_CLKS with no byte -> silently back to WAIT_B1.
  - A frame_err while in WAIT_B2 also abandons the command and returns to WAIT_B1 without cmd_err.
  - Timeout and byte arrival in the same cycle: the byte wins.
- Re-sending the currently active command re-applies it and pulses cmd_valid again.
- Counter widths: ceil(log2(CLKS_PER_BIT+1)) for the bit counter, ceil(log2(TIMEOUT_CLKS+1)) for the timeout counter. No wrap; both saturate and clear on state change.

Decomposition:
- Package singing_cmd_pkg holds:
  - CMD_ON=8'hFF, CMD_OFF=8'h00, NUM_FREQ=8.
  - Frequency code constants FREQ_12K=0 … FREQ_360M=7.
  - Bit-FSM and command-FSM state encodings.
- One sub-module, uart_rx_byte: synchroniser plus bit FSM. Outputs rx_byte, rx_byte_valid and frame_err.
- The command FSM lives in uart_cmd_rx.

Test Plan:
- Reset, then send 0xFF,0x03 at 57600 baud -> one cmd_valid pulse, osc_en=1, freq_sel=3, rx_byte=0x03, no err pulses.
- After the above, send 0x00,0x00 -> cmd_valid pulse, osc_en=0, freq_sel stays 3. Then send 0xFF,0x07 -> osc_en=1, freq_sel=7.
- Send 0xFF,0x09, then 0x5A alone -> two cmd_err pulses, osc_en/freq_sel unchanged, FSM back in WAIT_B1. A following 0xFF,0x01 gives freq_sel=1.
- Send a byte with stop bit driven low -> frame_err pulse, no rx_byte_valid. Also drive a 200-cycle low glitch on idle rx -> no pulses at all.
- Send 0xFF, idle 60000 cycles, then 0x02 -> 0x02 is treated as byte 1 and gives a cmd_err pulse. osc_en unchanged.
- Assert rst for 1 cycle during byte 2 of 0xFF,0x04 -> outputs reset to 0, no cmd_valid. A following full 0xFF,0x04 gives freq_sel=4, osc_en=1.
